clb_config_loader: RTL and testbench
====================================

// Module: clb_config_loader
// PURPOSE
//  Serial configuration loader that sits directly upstream of the CLB array.
//  Receives the configuration bitstream one bit per enabled clock, detects the
//  preamble, and deframes NUM_CLB per-CLB frames with parity and stop-bit checks.
//  Each good frame becomes one parallel write (cfg_addr/cfg_data) into that CLB's
//  config registers. Raises done after the last frame; err is sticky on a bad frame.
// PARAMETERS
//  CFG_W    37  config bits per CLB (layout below)
//  NUM_CLB  4   frames expected after preamble
//  AW       2   cfg_addr width, >= clog2(NUM_CLB)
// PORTS
//  K         in   1      clock, rising edge
//  RST       in   1      reset, asynchronous, active-high
//  CE        in   1      bit enable; DIN sampled only on K edges with CE=1
//  DIN       in   1      serial bitstream
//  cfg_we    out  1      one-cycle write strobe to CLB config regs
//  cfg_addr  out  AW     target CLB index
//  cfg_data  out  CFG_W  config word
//  busy      out  1      preamble seen, frames in progress
//  done      out  1      all NUM_CLB frames written
//  err       out  1      sticky parity/stop error
// BEHAVIOUR
//  cfg_data map: [15:0] LUT mem, [17:16] comboption, [19:18] mux2sel, [21:20] mux3sel,
//   [23:22] mux4sel, [25:24] mux5sel, [27:26] mux6sel, [30:28] o2m1_0/o2m2_0/o2m3_0,
//   [33:31] o2m1_1/o2m2_1/o2m3_1, [34] DQmux1, [35] DQmux2, [36] floporlatch.
//  Reset: all outputs 0, state IDLE, preamble shreg all 0, frame/bit counters 0.
//  CE=0: state, counters, shreg and outputs hold; cfg_we still drops after its cycle.
//  FSM (advances only on CE=1):
//   IDLE : shift DIN into 8b shreg (new bit at LSB); when {shreg[6:0],DIN}==8'hF2
//          -> START, busy=1.
//   START: DIN=1 idle fill, stay; DIN=0 start bit -> DATA, bit count 0.
//   DATA : CFG_W bits, LSB first into shift reg; after bit CFG_W-1 -> PAR.
//   PAR  : DIN must equal XOR of data bits (even parity over data+parity) -> STOP.
//   STOP : DIN=1 and parity ok -> frame good; DIN=0 or parity bad -> ERR.
//          Good frame: next cycle cfg_we=1 for exactly one K cycle, with
//          cfg_addr=frame index, cfg_data=word; both held until next write.
//          Frame index increments; after index NUM_CLB-1 -> DONE, else START.
//   DONE : done=1, busy=0; DIN ignored until RST.
//   ERR  : err=1, busy=0, no write for failed frame; DIN ignored until RST.
//  Latency: cfg_we rises one K cycle after the edge sampling a valid stop bit.
//  done rises on the same cycle as the last cfg_we.
//  Preamble bits overlapping an earlier partial match are honoured (sliding compare).
//  Preamble pattern appearing inside frame data is not re-detected.
//  RST mid-frame: partial frame discarded, no cfg_we, restart in IDLE.
// TESTING
//  1. RST; CE=1; send F2, 4 good frames with data 0x0_0000_0116 -> 4 cfg_we pulses,
//     addr 0..3, cfg_data=37'h116, done=1 with last pulse, err=0.
//  2. Frame 1 parity bit flipped -> err=1 after its stop bit, only addr 0 written,
//     done stays 0, further DIN ignored.
//  3. Frame 0 stop bit=0 -> err=1, no cfg_we at all.
//  4. CE toggled 1/0 every cycle over test 1 stream -> identical writes/values,
//     each cfg_we exactly one cycle wide.
//  5. Stream 1111_1111_0010 with 3 idle 1s between frames -> lock on F2, fill ignored,
//     all frames written correctly.
//  6. RST asserted mid-DATA of frame 2 -> outputs 0 same cycle; resend full stream
//     -> writes restart at addr 0.

Source files
------------

// File: rtl/clb_config_loader.sv
// clb_config_loader: serial bitstream deframer feeding per-CLB config writes.
// Locks on the 0xF2 preamble, then checks parity and stop bit on each of NUM_CLB frames.
module clb_config_loader #(
    parameter int CFG_W   = 37,
    parameter int NUM_CLB = 4,
    parameter int AW      = 2
) (
    input  logic             K,
    input  logic             RST,
    input  logic             CE,
    input  logic             DIN,
    output logic             cfg_we,
    output logic [AW-1:0]    cfg_addr,
    output logic [CFG_W-1:0] cfg_data,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int            BW         = $clog2(CFG_W);
    localparam logic [BW-1:0] LAST_BIT   = BW'(CFG_W - 1);
    localparam logic [AW-1:0] LAST_FRAME = AW'(NUM_CLB - 1);
    localparam logic [7:0]    PREAMBLE   = 8'hF2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        DONE,
        ERR
    } state_t;

    state_t state, state_nxt;

    // Only the seven oldest preamble bits are stored; DIN supplies the eighth.
    logic [6:0]       shreg;
    logic [CFG_W-1:0] word;
    logic [BW-1:0]    bit_cnt;
    logic [AW-1:0]    frame_idx;
    logic             par_acc;
    logic             par_ok;
    logic             preamble_hit;
    logic             stop_good;
    logic             last_frame;

    assign preamble_hit = ({shreg, DIN} == PREAMBLE);
    assign stop_good    = CE && (state == STOP) && DIN && par_ok;
    assign last_frame   = (frame_idx == LAST_FRAME);

    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (CE) begin
            case (state)
                IDLE:    if (preamble_hit) state_nxt = START;
                START:   if (!DIN) state_nxt = DATA;
                DATA:    if (bit_cnt == LAST_BIT) state_nxt = PAR;
                PAR:     state_nxt = STOP;
                STOP: begin
                    if (DIN && par_ok) begin
                        state_nxt = last_frame ? DONE : START;
                    end else begin
                        state_nxt = ERR;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        busy = (state == START) || (state == DATA) || (state == PAR) || (state == STOP);
        done = (state == DONE);
        err  = (state == ERR);
    end

    // The write strobe is refreshed every clock so it lasts one cycle even when CE drops.
    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            shreg     <= '0;
            word      <= '0;
            bit_cnt   <= '0;
            frame_idx <= '0;
            par_acc   <= 1'b0;
            par_ok    <= 1'b0;
            cfg_we    <= 1'b0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
        end else begin
            cfg_we <= stop_good;
            if (stop_good) begin
                cfg_addr  <= frame_idx;
                cfg_data  <= word;
                frame_idx <= frame_idx + AW'(1);
            end
            if (CE) begin
                case (state)
                    IDLE:  shreg <= {shreg[5:0], DIN};
                    START: begin
                        if (!DIN) begin
                            bit_cnt <= '0;
                            par_acc <= 1'b0;
                        end
                    end
                    DATA: begin
                        word    <= {DIN, word[CFG_W-1:1]};
                        par_acc <= par_acc ^ DIN;
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                    PAR:     par_ok <= (DIN == par_acc);
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_clb_config_loader.sv
// tb_clb_config_loader: table-driven and randomized streams checked against a
// bitstream-parsing reference model that predicts every config write.
module tb_clb_config_loader;
    localparam int         CFG_W    = 37;
    localparam int         NUM_CLB  = 4;
    localparam int         AW       = 2;
    localparam logic [7:0] PREAMBLE = 8'hF2;

    logic             K = 1'b0;
    logic             RST = 1'b0;
    logic             CE = 1'b0;
    logic             DIN = 1'b0;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [CFG_W-1:0] cfg_data;
    logic             busy;
    logic             done;
    logic             err;

    clb_config_loader #(.CFG_W(CFG_W), .NUM_CLB(NUM_CLB), .AW(AW)) dut (
        .K(K), .RST(RST), .CE(CE), .DIN(DIN),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 K = ~K;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [CFG_W-1:0] data;
        int               step;
    } wr_t;

    typedef struct {
        string name;
        int    lead_ones;
        int    fill;
        int    ce_mode;
        int    bad_par;
        int    bad_stop;
        int    exp_writes;
        bit    exp_done;
        bit    exp_err;
    } vec_t;

    int  checks = 0;
    int  errors = 0;
    int  step_cnt, done_step, err_step, we_run, max_we_run, ce_mode;
    bit  prev_done, prev_err;
    bit  s_ce[$];
    bit  s_din[$];
    wr_t got_wr[$];
    wr_t exp_wr[$];
    bit  exp_done, exp_err, exp_busy;
    int  exp_done_step, exp_err_step;
    logic [CFG_W-1:0] fdata[NUM_CLB];
    vec_t vecs[6];

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic void push_bit(input bit d);
        case (ce_mode)
            1: begin
                s_ce.push_back(1'b1); s_din.push_back(d);
                s_ce.push_back(1'b0); s_din.push_back(1'($urandom));
            end
            2: begin
                while ($urandom_range(0, 2) == 0) begin
                    s_ce.push_back(1'b0); s_din.push_back(1'($urandom));
                end
                s_ce.push_back(1'b1); s_din.push_back(d);
            end
            default: begin
                s_ce.push_back(1'b1); s_din.push_back(d);
            end
        endcase
    endfunction

    function automatic void build_stream(input int prefix_len, input int lead_ones, input int fill,
                                         input int bad_par, input int bad_stop);
        s_ce.delete();
        s_din.delete();
        repeat (prefix_len) push_bit(1'($urandom));
        repeat (lead_ones) push_bit(1'b1);
        for (int i = 7; i >= 0; i--) push_bit(PREAMBLE[i]);
        for (int f = 0; f < NUM_CLB; f++) begin
            push_bit(1'b0);
            for (int k = 0; k < CFG_W; k++) push_bit(fdata[f][k]);
            push_bit((^fdata[f]) ^ (f == bad_par));
            push_bit((f == bad_stop) ? 1'b0 : 1'b1);
            repeat (fill) push_bit(1'b1);
        end
        repeat (12) push_bit(1'($urandom));
    endfunction

    // Parses the sampled bit string directly: find the preamble, then walk whole frames.
    function automatic void run_model();
        bit               b[$];
        int               pos[$];
        int               p;
        bit               hit;
        logic [CFG_W-1:0] w;
        exp_wr.delete();
        exp_done = 0; exp_err = 0; exp_busy = 0;
        exp_done_step = -1; exp_err_step = -1;
        for (int i = 0; i < s_din.size(); i++) begin
            if (s_ce[i]) begin
                b.push_back(s_din[i]);
                pos.push_back(i);
            end
        end
        p = -1;
        for (int i = 7; i < b.size() && p < 0; i++) begin
            hit = 1;
            for (int k = 0; k < 8; k++) if (b[i-7+k] != PREAMBLE[7-k]) hit = 0;
            if (hit) p = i + 1;
        end
        if (p < 0) return;
        exp_busy = 1;
        for (int f = 0; f < NUM_CLB; f++) begin
            while (p < b.size() && b[p] == 1'b1) p++;
            if (p + CFG_W + 3 > b.size()) return;
            p++;
            w = '0;
            for (int k = 0; k < CFG_W; k++) w[k] = b[p+k];
            if (b[p+CFG_W] != (^w) || b[p+CFG_W+1] == 1'b0) begin
                exp_err = 1; exp_busy = 0;
                exp_err_step = pos[p+CFG_W+1];
                return;
            end
            exp_wr.push_back('{AW'(f), w, pos[p+CFG_W+1]});
            p += CFG_W + 2;
        end
        exp_done = 1; exp_busy = 0;
        exp_done_step = exp_wr[$].step;
    endfunction

    task automatic apply_stimulus(input bit ce, input bit din);
        @(negedge K);
        CE = ce;
        DIN = din;
        @(posedge K);
        #1;
        if (cfg_we) begin
            got_wr.push_back('{cfg_addr, cfg_data, step_cnt});
            we_run++;
            if (we_run > max_we_run) max_we_run = we_run;
        end else begin
            we_run = 0;
        end
        if (done && !prev_done) done_step = step_cnt;
        if (err && !prev_err) err_step = step_cnt;
        prev_done = done;
        prev_err = err;
        step_cnt++;
    endtask

    task automatic do_reset(input string tag);
        @(negedge K);
        RST = 1'b1;
        CE = 1'b0;
        #1;
        check_output({tag, "/rst_we"}, 64'(cfg_we), 0);
        check_output({tag, "/rst_addr"}, 64'(cfg_addr), 0);
        check_output({tag, "/rst_data"}, 64'(cfg_data), 0);
        check_output({tag, "/rst_flags"}, 64'({busy, done, err}), 0);
        @(negedge K);
        RST = 1'b0;
    endtask

    task automatic clear_record();
        got_wr.delete();
        step_cnt = 0; done_step = -1; err_step = -1;
        we_run = 0; max_we_run = 0; prev_done = 0; prev_err = 0;
    endtask

    task automatic run_stream(input bit rst_first, input string tag);
        if (rst_first) do_reset(tag);
        clear_record();
        for (int i = 0; i < s_din.size(); i++) apply_stimulus(s_ce[i], s_din[i]);
        run_model();
        check_output({tag, "/write_count"}, 64'(got_wr.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            check_output($sformatf("%s/addr%0d", tag, i), 64'(got_wr[i].addr), 64'(exp_wr[i].addr));
            check_output($sformatf("%s/data%0d", tag, i), 64'(got_wr[i].data), 64'(exp_wr[i].data));
            check_output($sformatf("%s/step%0d", tag, i), 64'(got_wr[i].step), 64'(exp_wr[i].step));
        end
        check_output({tag, "/done"}, 64'(done), 64'(exp_done));
        check_output({tag, "/err"}, 64'(err), 64'(exp_err));
        check_output({tag, "/busy"}, 64'(busy), 64'(exp_busy));
        check_output({tag, "/we_width"}, 64'(max_we_run), (exp_wr.size() > 0) ? 64'd1 : 64'd0);
        if (exp_done) check_output({tag, "/done_step"}, 64'(done_step), 64'(exp_done_step));
        if (exp_err) check_output({tag, "/err_step"}, 64'(err_step), 64'(exp_err_step));
        if (exp_wr.size() > 0) begin
            check_output({tag, "/hold_addr"}, 64'(cfg_addr), 64'(exp_wr[$].addr));
            check_output({tag, "/hold_data"}, 64'(cfg_data), 64'(exp_wr[$].data));
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{"basic",     0, 0, 0, -1, -1, 4, 1'b1, 1'b0};
        vecs[1] = '{"par_f1",    0, 0, 0,  1, -1, 1, 1'b0, 1'b1};
        vecs[2] = '{"stop_f0",   0, 0, 0, -1,  0, 0, 1'b0, 1'b1};
        vecs[3] = '{"ce_toggle", 0, 0, 1, -1, -1, 4, 1'b1, 1'b0};
        vecs[4] = '{"fill",      4, 3, 0, -1, -1, 4, 1'b1, 1'b0};
        vecs[5] = '{"stop_f3",   0, 2, 1, -1,  3, 3, 1'b0, 1'b1};

        for (int v = 0; v < 6; v++) begin
            for (int f = 0; f < NUM_CLB; f++) fdata[f] = 37'h116;
            ce_mode = vecs[v].ce_mode;
            build_stream(0, vecs[v].lead_ones, vecs[v].fill, vecs[v].bad_par, vecs[v].bad_stop);
            run_stream(1'b1, vecs[v].name);
            check_output({vecs[v].name, "/tbl_writes"}, 64'(got_wr.size()), 64'(vecs[v].exp_writes));
            check_output({vecs[v].name, "/tbl_done"}, 64'(done), 64'(vecs[v].exp_done));
            check_output({vecs[v].name, "/tbl_err"}, 64'(err), 64'(vecs[v].exp_err));
        end

        // Reset in the middle of frame 2 data, then replay the whole stream.
        for (int f = 0; f < NUM_CLB; f++) fdata[f] = 37'h116;
        ce_mode = 0;
        build_stream(0, 0, 0, -1, -1);
        do_reset("midrst");
        clear_record();
        for (int i = 0; i < 8 + 2 * (CFG_W + 2) + 20; i++) apply_stimulus(s_ce[i], s_din[i]);
        check_output("midrst/pre_writes", 64'(got_wr.size()), 64'd2);
        check_output("midrst/pre_busy", 64'(busy), 64'd1);
        #2;
        RST = 1'b1;
        #1;
        check_output("midrst/async_addr", 64'(cfg_addr), 0);
        check_output("midrst/async_data", 64'(cfg_data), 0);
        check_output("midrst/async_flags", 64'({cfg_we, busy, done, err}), 0);
        @(negedge K);
        RST = 1'b0;
        run_stream(1'b0, "midrst_replay");

        for (int r = 0; r < 25; r++) begin
            int bp, bs;
            for (int f = 0; f < NUM_CLB; f++) fdata[f] = CFG_W'({$urandom(), $urandom()});
            ce_mode = $urandom_range(0, 2);
            bp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NUM_CLB - 1)) : -1;
            bs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_CLB - 1)) : -1;
            build_stream($urandom_range(0, 10), $urandom_range(0, 5), $urandom_range(0, 3), bp, bs);
            run_stream(1'b1, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
